// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: sequencer state encodings,
// the silent frequency word and the channel slot indices in a pattern step.
package note_sequencer_pkg;

  typedef logic [7:0] freq_t;

  localparam logic [1:0] SEQ_IDLE  = 2'd0;
  localparam logic [1:0] SEQ_PLAY  = 2'd1;
  localparam logic [1:0] SEQ_PAUSE = 2'd2;

  localparam freq_t FREQ_SILENT = 8'd0;

  // Channel slot within a step, matching the low two bits of wr_addr.
  localparam logic [1:0] CH_SQ1   = 2'd0;
  localparam logic [1:0] CH_SQ2   = 2'd1;
  localparam logic [1:0] CH_SAW   = 2'd2;
  localparam logic [1:0] CH_NOISE = 2'd3;

endpackage

// File: rtl/note_sequencer_pattern_ram.sv
// Pattern store: STEPS x 4 frequency words, one synchronous write port and
// four asynchronous read ports that all look at the same step.
module pattern_ram
  import note_sequencer_pkg::*;
#(
  parameter  int STEPS = 16,
  localparam int SW    = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [SW+1:0] wr_addr,
  input  freq_t         wr_data,
  input  logic [SW-1:0] rd_step,
  output freq_t         rd_sq1,
  output freq_t         rd_sq2,
  output freq_t         rd_saw,
  output freq_t         rd_noise
);

  // Contents survive reset so a pattern outlives a sequencer restart.
  freq_t mem [STEPS][4];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[SW+1:2]][wr_addr[1:0]] <= wr_data;
    end
  end

  assign rd_sq1   = mem[rd_step][CH_SQ1];
  assign rd_sq2   = mem[rd_step][CH_SQ2];
  assign rd_saw   = mem[rd_step][CH_SAW];
  assign rd_noise = mem[rd_step][CH_NOISE];

endmodule

// File: rtl/note_sequencer.sv
// Tempo-driven 4-channel pattern sequencer: play/pause/stop FSM, per-step tick
// counter with note gating, and decode of the stored pattern onto freq1..freq4.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter  int STEPS = 16,
  parameter  int TW    = 24,
  localparam int SW    = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          play,
  input  logic          pause,
  input  logic          stop,
  input  logic [TW-1:0] tempo,
  input  logic [TW-1:0] gate_len,
  input  logic [SW-1:0] last_step,
  input  logic          wr_en,
  input  logic [SW+1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic [7:0]    freq1,
  output logic [7:0]    freq2,
  output logic [7:0]    freq3,
  output logic [7:0]    freq4,
  output logic [SW-1:0] step_idx,
  output logic          step_pulse,
  output logic          playing
);

  function automatic logic [TW-1:0] tempo_floor(input logic [TW-1:0] t);
    return (t == '0) ? TW'(1) : t;
  endfunction

  logic [1:0]    state;
  logic [TW-1:0] tick;
  logic [TW-1:0] tempo_q;
  logic [TW-1:0] gate_q;
  logic [SW-1:0] step;
  logic          pulse_q;

  logic          is_play;
  logic          boundary;
  logic [SW-1:0] next_step;
  logic          sounding;
  freq_t         ram_sq1, ram_sq2, ram_saw, ram_noise;

  assign is_play   = (state == SEQ_PLAY);
  assign boundary  = is_play && (tick == tempo_q - TW'(1));
  // Wrap on the loop end or by natural overflow; a loop end lowered below
  // the current step therefore plays on to the last step before wrapping.
  assign next_step = (step == last_step) ? '0 : step + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEQ_IDLE;
      tick    <= '0;
      step    <= '0;
      tempo_q <= TW'(1);
      gate_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (stop) begin
        state <= SEQ_IDLE;
        tick  <= '0;
        step  <= '0;
      end else begin
        case (state)
          SEQ_IDLE: begin
            if (play) begin
              state   <= SEQ_PLAY;
              tick    <= '0;
              step    <= '0;
              tempo_q <= tempo_floor(tempo);
              gate_q  <= gate_len;
              pulse_q <= 1'b1;
            end
          end
          SEQ_PLAY: begin
            // The pausing edge still completes the current cycle of playback,
            // so every step sounds for exactly tempo_q played cycles.
            if (boundary) begin
              tick    <= '0;
              step    <= next_step;
              tempo_q <= tempo_floor(tempo);
              gate_q  <= gate_len;
              pulse_q <= !pause;
            end else begin
              tick <= tick + TW'(1);
            end
            if (pause) begin
              state <= SEQ_PAUSE;
            end
          end
          SEQ_PAUSE: begin
            if (play) begin
              state <= SEQ_PLAY;
            end
          end
          default: state <= SEQ_IDLE;
        endcase
      end
    end
  end

  pattern_ram #(
    .STEPS(STEPS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_step (step),
    .rd_sq1  (ram_sq1),
    .rd_sq2  (ram_sq2),
    .rd_saw  (ram_saw),
    .rd_noise(ram_noise)
  );

  assign sounding   = is_play && (tick < gate_q);
  assign freq1      = sounding ? ram_sq1   : FREQ_SILENT;
  assign freq2      = sounding ? ram_sq2   : FREQ_SILENT;
  assign freq3      = sounding ? ram_saw   : FREQ_SILENT;
  assign freq4      = sounding ? ram_noise : FREQ_SILENT;
  assign step_idx   = step;
  assign playing    = is_play;
  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a step/elapsed-time model.
module tb_note_sequencer;

  localparam int STEPS = 16;
  localparam int TW    = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          play, pause, stop;
  logic [TW-1:0] tempo, gate_len;
  logic [3:0]    last_step;
  logic          wr_en;
  logic [5:0]    wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    freq1, freq2, freq3, freq4;
  logic [3:0]    step_idx;
  logic          step_pulse, playing;

  int checks = 0;
  int errors = 0;

  note_sequencer #(.STEPS(STEPS), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .pause(pause), .stop(stop),
    .tempo(tempo), .gate_len(gate_len), .last_step(last_step),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .freq1(freq1), .freq2(freq2), .freq3(freq3), .freq4(freq4),
    .step_idx(step_idx), .step_pulse(step_pulse), .playing(playing)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 playing, 2 paused; elapsed = played cycles in step.
  int         m_mode, m_step, m_elapsed, m_len, m_gate;
  bit         m_pulse;
  logic [7:0] m_mem [STEPS][4];

  always @(posedge clk or negedge rst_n) begin : model
    int mode, stp, el, len, gt;
    bit pl;
    if (!rst_n) begin
      m_mode <= 0; m_step <= 0; m_elapsed <= 0; m_len <= 1; m_gate <= 0; m_pulse <= 0;
    end else begin
      mode = m_mode; stp = m_step; el = m_elapsed; len = m_len; gt = m_gate; pl = 0;
      if (stop) begin
        mode = 0; stp = 0; el = 0;
      end else if (mode == 1) begin
        if (el + 1 >= len) begin
          stp = (stp == int'(last_step)) ? 0 : (stp + 1) % STEPS;
          el  = 0;
          len = (tempo == 0) ? 1 : int'(tempo);
          gt  = int'(gate_len);
          pl  = !pause;
        end else begin
          el = el + 1;
        end
        if (pause) mode = 2;
      end else if (play) begin
        if (mode == 0) begin
          stp = 0; el = 0; pl = 1;
          len = (tempo == 0) ? 1 : int'(tempo);
          gt  = int'(gate_len);
        end
        mode = 1;
      end
      m_mode <= mode; m_step <= stp; m_elapsed <= el; m_len <= len; m_gate <= gt; m_pulse <= pl;
      if (wr_en) m_mem[wr_addr[5:2]][wr_addr[1:0]] <= wr_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_freq(input int ch);
    return (m_mode == 1 && m_elapsed < m_gate) ? m_mem[m_step][ch] : 8'd0;
  endfunction

  task automatic compare_all();
    chk("freq1", freq1, m_freq(0));
    chk("freq2", freq2, m_freq(1));
    chk("freq3", freq3, m_freq(2));
    chk("freq4", freq4, m_freq(3));
    chk("step_idx", step_idx, m_step[3:0]);
    chk("step_pulse", step_pulse, m_pulse);
    chk("playing", playing, m_mode == 1);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_play();  play = 1;  step(); play = 0;  endtask
  task automatic pulse_stop();  stop = 1;  step(); stop = 0;  endtask
  task automatic pulse_pause(); pause = 1; step(); pause = 0; endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_f1"}, freq1, 0);
    chk({nm, "_f2"}, freq2, 0);
    chk({nm, "_f3"}, freq3, 0);
    chk({nm, "_f4"}, freq4, 0);
    chk({nm, "_step"}, step_idx, 0);
    chk({nm, "_pulse"}, step_pulse, 0);
    chk({nm, "_playing"}, playing, 0);
  endtask

  int vals[4] = '{10, 20, 30, 40};

  initial begin
    rst_n = 0; play = 0; pause = 0; stop = 0;
    tempo = 4; gate_len = 4; last_step = 3;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1;

    // Fill the whole pattern, then the ch1 words of steps 0..3.
    for (int a = 0; a < 64; a++) begin
      wr_en = 1; wr_addr = 6'(a); wr_data = 8'($urandom_range(1, 255));
      step();
    end
    for (int s = 0; s < 4; s++) begin
      wr_addr = 6'(s * 4); wr_data = 8'(vals[s]);
      step();
    end
    wr_en = 0;

    // Basic play
    pulse_play();
    for (int k = 0; k < 20; k++) begin
      chk("basic_f1", freq1, vals[(k / 4) % 4]);
      chk("basic_pulse", step_pulse, (k % 4) == 0);
      if (k < 19) step();
    end
    pulse_stop();
    chk("stop_f1", freq1, 0);
    chk("stop_step", step_idx, 0);

    // Gating
    tempo = 8; gate_len = 3;
    pulse_play();
    for (int k = 0; k < 16; k++) begin
      chk("gate_f1", freq1, (k % 8 < 3) ? vals[k / 8] : 0);
      if (k < 15) step();
    end
    pulse_stop();
    gate_len = 0;
    pulse_play();
    for (int k = 0; k < 8; k++) begin
      chk("gate0_f1", freq1, 0);
      chk("gate0_f2", freq2, 0);
      chk("gate0_playing", playing, 1);
      step();
    end
    pulse_stop();

    // Pause at tick 2 of step 1, resume after 10 cycles
    tempo = 4; gate_len = 4;
    pulse_play();
    repeat (6) step();
    chk("pre_pause_step", step_idx, 1);
    chk("pre_pause_f1", freq1, 20);
    pulse_pause();
    for (int k = 0; k < 10; k++) begin
      chk("paused_f1", freq1, 0);
      chk("paused_playing", playing, 0);
      chk("paused_step", step_idx, 1);
      step();
    end
    pulse_play();
    chk("resume_f1", freq1, 20);
    chk("resume_pulse", step_pulse, 0);
    step();
    chk("resume_next_step", step_idx, 2);
    chk("resume_next_pulse", step_pulse, 1);
    chk("resume_next_f1", freq1, 30);
    pulse_stop();

    // Priority and stop mid-step
    play = 1; stop = 1; step(); play = 0; stop = 0;
    chk("play_stop_playing", playing, 0);
    pulse_play();
    repeat (9) step();
    chk("mid2_step", step_idx, 2);
    pulse_stop();
    chk("stop2_step", step_idx, 0);
    chk("stop2_f1", freq1, 0);
    chk("stop2_playing", playing, 0);
    pulse_play();
    chk("restart_f1", freq1, 10);
    chk("restart_pulse", step_pulse, 1);

    // Live tempo change and write to the playing step
    tempo = 6;
    repeat (3) step();
    chk("live_still0", step_idx, 0);
    step();
    chk("live_step1", step_idx, 1);
    chk("live_pulse1", step_pulse, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("live_hold1", step_idx, 1);
    end
    step();
    chk("live_step2", step_idx, 2);
    wr_en = 1; wr_addr = {4'd2, 2'd1}; wr_data = 8'hA5;
    step();
    wr_en = 0;
    chk("live_wr_f2", freq2, 8'hA5);

    // Asynchronous reset mid-play
    #2 rst_n = 0;
    #1 chk_quiet("async_rst");
    @(negedge clk);
    rst_n = 1;
    tempo = 4;
    pulse_play();
    chk("after_rst_f1", freq1, 10);
    repeat (4) step();
    chk("after_rst_f1_s1", freq1, 20);
    repeat (4) step();
    chk("after_rst_f2_s2", freq2, 8'hA5);
    pulse_stop();

    // Tempo 0 advances every cycle
    tempo = 0;
    pulse_play();
    for (int k = 0; k < 6; k++) begin
      chk("t0_step", step_idx, 4'(k % 4));
      chk("t0_pulse", step_pulse, 1);
      step();
    end
    pulse_stop();

    // Randomized run
    tempo = 3; gate_len = 2; last_step = 7;
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      stop  = (r <= 2);
      play  = (r == 1) || (r >= 6 && r <= 10);
      pause = (r == 2) || (r >= 3 && r <= 5);
      if ($urandom_range(0, 7) == 0) tempo = TW'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) gate_len = TW'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) last_step = 4'($urandom_range(0, 15));
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_addr = 6'($urandom_range(0, 63));
      wr_data = 8'($urandom);
      step();
    end
    play = 0; pause = 0; stop = 0; wr_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
